// File: rtl/prog_sequencer.sv
// Loader/runner for a serially-programmed processor: holds it in reset,
// shifts a ROM program MSB-first on mosi_out, then runs it until done_in or a timeout.
module prog_sequencer #(
    parameter int CLK_DIV    = 4,
    parameter int PROG_LEN   = 16,
    parameter int RST_CYCLES = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic [$clog2(PROG_LEN)-1:0] rom_addr,
    input  logic [7:0]                  rom_data,
    output logic                        sclk_out,
    output logic                        rst_n_out,
    output logic [1:0]                  mode_out,
    output logic                        mosi_out,
    input  logic                        done_in,
    output logic                        busy,
    output logic                        done_o,
    output logic                        err
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RESET = 3'd1;
    localparam logic [2:0] S_LOAD  = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    localparam int AW   = $clog2(PROG_LEN);
    localparam int DW   = $clog2(CLK_DIV);
    localparam int BW   = $clog2(PROG_LEN * 8);
    localparam int MAXC = (TIMEOUT > RST_CYCLES) ? TIMEOUT : RST_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    logic [2:0]    r_state;
    logic [DW-1:0] r_div;
    logic          r_sclk;
    logic [CW-1:0] r_cnt;
    logic [BW-1:0] r_bitcnt;
    logic [7:0]    r_shift;
    logic          r_mosi;
    logic [AW-1:0] r_addr;
    logic          r_done_q;

    logic w_active;
    logic w_tick;
    logic w_rise;
    logic w_fall;

    assign w_active = (r_state == S_RESET) || (r_state == S_LOAD) || (r_state == S_RUN);
    assign w_tick   = w_active && (r_div == DW'(CLK_DIV - 1));
    assign w_rise   = w_tick && !r_sclk;
    assign w_fall   = w_tick && r_sclk;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_div    <= '0;
            r_sclk   <= 1'b0;
            r_cnt    <= '0;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_mosi   <= 1'b0;
            r_addr   <= '0;
            r_done_q <= 1'b0;
        end else begin
            r_done_q <= done_in;
            if (w_active) begin
                if (w_tick) begin
                    r_div  <= '0;
                    r_sclk <= ~r_sclk;
                end else begin
                    r_div <= r_div + 1'b1;
                end
            end
            case (r_state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (start) begin
                        r_state  <= S_RESET;
                        r_div    <= '0;
                        r_sclk   <= 1'b0;
                        r_cnt    <= '0;
                        r_bitcnt <= '0;
                        r_mosi   <= 1'b0;
                        r_addr   <= '0;
                    end
                end
                S_RESET: begin
                    if (w_rise) r_cnt <= r_cnt + 1'b1;
                    // byte 0 has been stable on rom_data for the whole reset phase
                    if (w_fall && r_cnt == CW'(RST_CYCLES)) begin
                        r_state  <= S_LOAD;
                        r_shift  <= rom_data;
                        r_mosi   <= rom_data[7];
                        r_addr   <= r_addr + 1'b1;
                        r_bitcnt <= '0;
                    end
                end
                S_LOAD: begin
                    if (w_fall) begin
                        if (r_bitcnt == BW'(PROG_LEN * 8 - 1)) begin
                            r_state <= S_RUN;
                            r_mosi  <= 1'b0;
                            r_cnt   <= '0;
                        end else begin
                            r_bitcnt <= r_bitcnt + 1'b1;
                            // rom_addr already points at the next byte, so its data is waiting here
                            if (r_bitcnt[2:0] == 3'd7) begin
                                r_shift <= rom_data;
                                r_mosi  <= rom_data[7];
                                r_addr  <= r_addr + 1'b1;
                            end else begin
                                r_shift <= {r_shift[6:0], 1'b0};
                                r_mosi  <= r_shift[6];
                            end
                        end
                    end
                end
                S_RUN: begin
                    if (w_rise && r_cnt != CW'(TIMEOUT)) r_cnt <= r_cnt + 1'b1;
                    if (r_done_q) begin
                        r_state <= S_DONE;
                        r_sclk  <= 1'b0;
                        r_div   <= '0;
                    end else if (r_cnt == CW'(TIMEOUT)) begin
                        r_state <= S_ERROR;
                        r_sclk  <= 1'b0;
                        r_div   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign rom_addr  = r_addr;
    assign sclk_out  = r_sclk;
    assign mosi_out  = r_mosi;
    assign rst_n_out = (r_state == S_LOAD) || (r_state == S_RUN) || (r_state == S_DONE);
    assign mode_out  = (r_state == S_LOAD) ? 2'b01 : (r_state == S_RUN) ? 2'b10 : 2'b00;
    assign busy      = w_active;
    assign done_o    = (r_state == S_DONE);
    assign err       = (r_state == S_ERROR);

endmodule

// File: tb/tb_prog_sequencer.sv
// Directed bench for prog_sequencer: load/run/done, timeout, restart and mid-load reset.
module tb_prog_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [0:0]  rom_addr;
    logic [7:0]  rom_data;
    logic        sclk_out;
    logic        rst_n_out;
    logic [1:0]  mode_out;
    logic        mosi_out;
    logic        done_in;
    logic        busy;
    logic        done_o;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    prog_sequencer #(.CLK_DIV(2), .PROG_LEN(2), .RST_CYCLES(2), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
        .sclk_out(sclk_out), .rst_n_out(rst_n_out), .mode_out(mode_out), .mosi_out(mosi_out),
        .done_in(done_in), .busy(busy), .done_o(done_o), .err(err)
    );

    always #5 clk = ~clk;

    // synchronous ROM: data valid one clk after the address
    always @(posedge clk) rom_data <= (rom_addr == 1'b0) ? 8'hA5 : 8'h3C;

    // edge monitor; counters restart whenever a sequence begins
    logic        prev_sclk = 1'b0;
    logic        prev_busy = 1'b0;
    int          rst_edges = 0;
    int          load_cnt  = 0;
    logic [15:0] load_bits = '0;
    int          run_edges = 0;
    int          rises_total = 0;
    logic        saw_run = 1'b0;

    always @(negedge clk) begin
        if (sclk_out && !prev_sclk) rises_total = rises_total + 1;
        if (busy && !prev_busy) begin
            rst_edges = 0;
            load_cnt  = 0;
            load_bits = '0;
            run_edges = 0;
            saw_run   = 1'b0;
        end else if (sclk_out && !prev_sclk) begin
            if (mode_out == 2'b00 && !rst_n_out && busy) rst_edges = rst_edges + 1;
            if (mode_out == 2'b01) begin
                load_bits = {load_bits[14:0], mosi_out};
                load_cnt  = load_cnt + 1;
            end
            if (mode_out == 2'b10) run_edges = run_edges + 1;
        end
        if (mode_out == 2'b10) saw_run = 1'b1;
        prev_sclk = sclk_out;
        prev_busy = busy;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_sclk"}, 32'(sclk_out), 0);
        chk({tag, "_rstn"}, 32'(rst_n_out), 0);
        chk({tag, "_mode"}, 32'(mode_out), 0);
        chk({tag, "_mosi"}, 32'(mosi_out), 0);
        chk({tag, "_addr"}, 32'(rom_addr), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done_o), 0);
        chk({tag, "_err"},  32'(err), 0);
    endtask

    int snap;

    initial begin
        rst = 1'b1; start = 1'b0; done_in = 1'b0;
        tick(); tick();
        chk_idle_reset("rst");
        rst = 1'b0;
        tick();

        // basic load then done after 5 run edges
        start = 1'b1; tick(); start = 1'b0;
        chk("a_busy", 32'(busy), 1);
        for (int i = 0; i < 500 && mode_out != 2'b10; i++) tick();
        chk("a_run_to", 32'(mode_out), 2);
        chk("a_rst_edges", 32'(rst_edges), 2);
        chk("a_load_cnt", 32'(load_cnt), 16);
        chk("a_bits", 32'(load_bits), 32'h0000A53C);
        chk("a_mosi_run", 32'(mosi_out), 0);
        chk("a_rstn_run", 32'(rst_n_out), 1);
        for (int i = 0; i < 500 && run_edges < 5; i++) tick();
        chk("a_run5_to", 32'(run_edges), 5);
        done_in = 1'b1;
        tick(); tick();
        chk("a_done", 32'(done_o), 1);
        chk("a_done_sclk", 32'(sclk_out), 0);
        chk("a_done_mode", 32'(mode_out), 0);
        chk("a_done_rstn", 32'(rst_n_out), 1);
        chk("a_done_busy", 32'(busy), 0);

        // restart from DONE, start held through LOAD, done_in high throughout
        start = 1'b1; tick();
        chk("b_done_clr", 32'(done_o), 0);
        chk("b_busy", 32'(busy), 1);
        chk("b_addr", 32'(rom_addr), 0);
        for (int i = 0; i < 500 && load_cnt < 9; i++) tick();
        chk("b_mode_load", 32'(mode_out), 1);
        start = 1'b0;
        for (int i = 0; i < 500 && !done_o; i++) tick();
        chk("b_done_to", 32'(done_o), 1);
        chk("b_saw_run", 32'(saw_run), 1);
        chk("b_rst_edges", 32'(rst_edges), 2);
        chk("b_load_cnt", 32'(load_cnt), 16);
        chk("b_bits", 32'(load_bits), 32'h0000A53C);
        chk("b_run_edges", 32'(run_edges), 0);
        done_in = 1'b0;
        tick();

        // timeout
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 500 && !err; i++) tick();
        chk("c_err_to", 32'(err), 1);
        chk("c_run_edges", 32'(run_edges), 8);
        chk("c_rstn", 32'(rst_n_out), 0);
        chk("c_mode", 32'(mode_out), 0);
        chk("c_sclk", 32'(sclk_out), 0);
        chk("c_done", 32'(done_o), 0);
        tick(); tick();
        chk("c_err_hold", 32'(err), 1);

        // restart from ERROR, then reset at bit 9 of LOAD
        start = 1'b1; tick(); start = 1'b0;
        chk("d_err_clr", 32'(err), 0);
        chk("d_busy", 32'(busy), 1);
        for (int i = 0; i < 500 && load_cnt < 9; i++) tick();
        chk("d_load9_to", 32'(load_cnt), 9);
        rst = 1'b1; tick(); rst = 1'b0;
        chk_idle_reset("d_rst");
        snap = rises_total;
        for (int i = 0; i < 20; i++) tick();
        chk("d_no_sclk", 32'(rises_total - snap), 0);
        chk("d_idle_busy", 32'(busy), 0);

        // fresh run after mid-load reset reloads the whole program
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 500 && mode_out != 2'b10; i++) tick();
        chk("e_run_to", 32'(mode_out), 2);
        chk("e_bits", 32'(load_bits), 32'h0000A53C);
        chk("e_load_cnt", 32'(load_cnt), 16);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/prog_sequencer.md
PROG_SEQUENCER -- requirements
Module: prog_sequencer

Interface
REQ-001 SHALL have parameter CLK_DIV, default 4: clk cycles per sclk_out half-period (>=2).
REQ-002 SHALL have parameter PROG_LEN, default 16: program bytes loaded per run (power of 2, 2..256).
REQ-003 SHALL have parameter RST_CYCLES, default 8: sclk periods with rst_n_out held low before load.
REQ-004 SHALL have parameter TIMEOUT, default 1024: maximum sclk rising edges in RUN before error.
REQ-005 SHALL have port clk  in  1  system clock; the only clock.
REQ-006 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-007 SHALL have port start  in  1  level, sampled per clk; starts a sequence from IDLE, DONE or ERROR.
REQ-008 SHALL have port rom_addr  out  $clog2(PROG_LEN)  program byte address.
REQ-009 SHALL have port rom_data  in  8  byte at rom_addr; valid one clk after rom_addr changes.
REQ-010 SHALL have port sclk_out  out  1  processor clock.
REQ-011 SHALL have port rst_n_out  out  1  processor active-low reset.
REQ-012 SHALL have port mode_out  out  2  processor mode: 00 hold, 01 load, 10 run; 11 never driven.
REQ-013 SHALL have port mosi_out  out  1  serial program bit to processor.
REQ-014 SHALL have port done_in  in  1  processor completion flag.
REQ-015 SHALL have ports busy, done_o and err  out  1 each: sequence active, finished, timed out.

Function
REQ-016 SHALL implement states IDLE, RESET_DUT, LOAD, RUN, DONE, ERROR.
REQ-017 SHALL run the sclk divider only in RESET_DUT, LOAD and RUN: toggle every CLK_DIV clk cycles, starting low; otherwise hold sclk_out at 0.
REQ-018 SHALL leave IDLE, DONE or ERROR for RESET_DUT on the clk edge where start=1; start is ignored in all other states.
REQ-019 SHALL, in RESET_DUT, drive rst_n_out=0 and mode_out=00 for RST_CYCLES sclk rising edges, then enter LOAD with rst_n_out=1.
REQ-020 SHALL, in LOAD, drive mode_out=01 and shift PROG_LEN*8 bits MSB-first, byte 0 first.
REQ-021 SHALL change mosi_out only on the clk edge where sclk_out goes 1->0, keeping it stable across each rising edge.
REQ-022 SHALL present bit 7 of byte 0 on mosi_out before the first LOAD rising edge.
REQ-023 SHALL prefetch byte k+1 during byte k, so that rom_data is captured at least one clk before it is needed; the shift sequence SHALL have no gap between bytes.
REQ-024 SHALL enter RUN on the falling edge after the final (PROG_LEN*8-th) rising edge, with mode_out=10 and mosi_out=0.
REQ-025 SHALL ignore done_in in every state except RUN.
REQ-026 SHALL register done_in once in the clk domain; in RUN, a registered done_in=1 SHALL cause entry to DONE.
REQ-027 SHALL count rising edges in RUN; when the count reaches TIMEOUT with no done, it SHALL enter ERROR; if done arrives on the same cycle, DONE SHALL win.
REQ-028 SHALL, in DONE, assert done_o=1, hold sclk_out=0 and mode_out=00, and keep rst_n_out=1.
REQ-029 SHALL, in ERROR, assert err=1, hold sclk_out=0 and mode_out=00, and drive rst_n_out=0.
REQ-030 SHALL assert busy=1 exactly in RESET_DUT, LOAD and RUN.
REQ-031 SHALL clear done_o and err on the clk edge that leaves DONE or ERROR for RESET_DUT.
REQ-032 SHALL wrap rom_addr to 0 on entry to RESET_DUT; it SHALL never exceed PROG_LEN-1.

Reset
REQ-033 SHALL, on rst=1 at a clk edge, enter IDLE with sclk_out=0, rst_n_out=0, mode_out=00, mosi_out=0, rom_addr=0, busy=0, done_o=0, err=0, and clear all counters.
REQ-034 SHALL apply reset identically when asserted mid-LOAD or mid-RUN; no partial shift SHALL continue after reset.

Verification
REQ-035 Setup CLK_DIV=2, PROG_LEN=2, RST_CYCLES=2, ROM={A5,3C}, start pulse -> 2 sclk edges with rst_n_out=0, then mode_out=01 and mosi 1010010100111100 on 16 rising edges, then mode_out=10.
REQ-036 Same setup, done_in=1 after 5 RUN edges -> DONE, done_o=1, sclk_out=0 and mode_out=00 within 2 clk.
REQ-037 Setup TIMEOUT=8, done_in held 0 -> ERROR after 8 RUN edges, err=1, rst_n_out=0.
REQ-038 Setup done_in=1 throughout LOAD -> LOAD runs all 16 bits, and DONE occurs only after RUN entry.
REQ-039 Setup rst pulse at bit 9 of LOAD -> all REQ-033 values on the next clk, then no sclk activity until start.
REQ-040 Setup start held high in LOAD, then a start in DONE -> first is ignored, second restarts with rom_addr=0 and done_o cleared.
